execute_mem_reg: RTL and testbench

EXECUTE_MEM_REG -- requirements
Module: execute_mem_reg

---
 rtl/cpu_types_pkg.sv | 32 +++
 rtl/execute_mem_reg_if.sv | 39 +++
 rtl/mem_wait_ctrl.sv | 65 ++++++
 rtl/execute_mem_reg.sv | 78 +++++++
 tb/tb_execute_mem_reg.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the EX/MEM pipeline register: memory-wait FSM states and
// the latched pipeline entry layout.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_WAIT   = 2'd1,
        MEM_HALTED = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rdat2;
        logic [31:0] pc_4;
        logic [31:0] br_target;
        logic [4:0]  wsel;
        logic        zero;
        logic        MemWr;
        logic        MemRd;
        logic        branch;
        logic        halt;
        logic        RegWr;
        logic [1:0]  PCSrc;
        logic [1:0]  MemtoReg;
    } exmem_t;

    // A bubble is an all-zero entry: no control side effects, zero data.
    localparam exmem_t EXMEM_BUBBLE = '0;

    localparam logic [7:0] WAIT_CNT_MAX = 8'hFF;

endpackage

// File: rtl/execute_mem_reg_if.sv
// Port bundle for the EX/MEM register: execute-stage inputs, latched mem_*
// outputs and the data-memory handshake.
interface execute_mem_reg_if;
    logic        EN;
    logic        flush;
    logic [31:0] exe_alu_out, exe_rdat2, exe_pc_4, exe_br_target;
    logic [4:0]  exe_wsel;
    logic        exe_zero, exe_MemWr, exe_MemRd, exe_branch, exe_halt, exe_RegWr;
    logic [1:0]  exe_PCSrc, exe_MemtoReg;
    logic [31:0] mem_alu_out, mem_rdat2, mem_pc_4, mem_br_target;
    logic [4:0]  mem_wsel;
    logic        mem_zero, mem_MemWr, mem_MemRd, mem_branch, mem_halt, mem_RegWr;
    logic [1:0]  mem_PCSrc, mem_MemtoReg;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore, mem_dload;
    logic        mem_stall, mem_timeout;

    modport execute_mem_reg (
        input  EN, flush, exe_alu_out, exe_rdat2, exe_pc_4, exe_br_target, exe_wsel,
               exe_zero, exe_MemWr, exe_MemRd, exe_branch, exe_halt, exe_RegWr,
               exe_PCSrc, exe_MemtoReg, dhit, dmemload,
        output mem_alu_out, mem_rdat2, mem_pc_4, mem_br_target, mem_wsel,
               mem_zero, mem_MemWr, mem_MemRd, mem_branch, mem_halt, mem_RegWr,
               mem_PCSrc, mem_MemtoReg, dmemREN, dmemWEN, dmemaddr, dmemstore,
               mem_dload, mem_stall, mem_timeout
    );

    modport tb (
        output EN, flush, exe_alu_out, exe_rdat2, exe_pc_4, exe_br_target, exe_wsel,
               exe_zero, exe_MemWr, exe_MemRd, exe_branch, exe_halt, exe_RegWr,
               exe_PCSrc, exe_MemtoReg, dhit, dmemload,
        input  mem_alu_out, mem_rdat2, mem_pc_4, mem_br_target, mem_wsel,
               mem_zero, mem_MemWr, mem_MemRd, mem_branch, mem_halt, mem_RegWr,
               mem_PCSrc, mem_MemtoReg, dmemREN, dmemWEN, dmemaddr, dmemstore,
               mem_dload, mem_stall, mem_timeout
    );
endinterface

// File: rtl/mem_wait_ctrl.sv
// Memory-access sequencing for the EX/MEM register: IDLE/WAIT/HALTED FSM,
// saturating wait counter and sticky watchdog.
import cpu_types_pkg::*;

module mem_wait_ctrl #(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_memop,
    input  logic       i_halt,
    input  logic       i_dhit,
    output mem_state_e o_state,
    output logic       o_advance,
    output logic       o_complete,
    output logic       o_timeout
);
    localparam logic [7:0] TIMEOUT_CNT = DMEM_TIMEOUT[7:0];

    mem_state_e r_state, w_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_inc;
    logic       r_timeout;

    always_comb begin
        w_next = r_state;
        case (r_state)
            MEM_IDLE: begin
                if (i_memop && !i_dhit) w_next = MEM_WAIT;
                else if (i_halt)        w_next = MEM_HALTED;
            end
            MEM_WAIT: begin
                if (i_dhit) w_next = i_halt ? MEM_HALTED : MEM_IDLE;
            end
            default: w_next = MEM_HALTED;
        endcase
    end

    // A halted entry is never replaced; an outstanding access must finish first.
    assign o_complete = (r_state != MEM_HALTED) && i_memop && i_dhit;
    assign o_advance  = (r_state == MEM_IDLE) && !i_halt && (!i_memop || i_dhit) && i_en;
    assign w_cnt_inc  = r_cnt + 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= MEM_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == MEM_IDLE && w_next == MEM_WAIT)
                r_cnt <= '0;
            else if (r_state == MEM_WAIT && r_cnt != WAIT_CNT_MAX)
                r_cnt <= w_cnt_inc;
            if (DMEM_TIMEOUT != 0 && r_state == MEM_WAIT && r_cnt != WAIT_CNT_MAX &&
                w_cnt_inc == TIMEOUT_CNT)
                r_timeout <= 1'b1;
        end
    end

    assign o_state   = r_state;
    assign o_timeout = r_timeout;

endmodule

// File: rtl/execute_mem_reg.sv
// EX/MEM pipeline register: latches execute results, drives the data-memory
// request from the latched entry and holds it until the access completes.
import cpu_types_pkg::*;

module execute_mem_reg #(
    parameter int DMEM_TIMEOUT = 255
) (
    input logic                              CLK,
    input logic                              RST,
    execute_mem_reg_if.execute_mem_reg       bus
);
    exmem_t     r_entry, w_exe;
    logic [31:0] r_dload;
    mem_state_e w_state;
    logic       w_advance, w_complete, w_timeout, w_memop, w_active;

    assign w_exe = '{alu_out: bus.exe_alu_out, rdat2: bus.exe_rdat2, pc_4: bus.exe_pc_4,
                     br_target: bus.exe_br_target, wsel: bus.exe_wsel, zero: bus.exe_zero,
                     MemWr: bus.exe_MemWr, MemRd: bus.exe_MemRd, branch: bus.exe_branch,
                     halt: bus.exe_halt, RegWr: bus.exe_RegWr, PCSrc: bus.exe_PCSrc,
                     MemtoReg: bus.exe_MemtoReg};

    assign w_memop  = r_entry.MemRd || r_entry.MemWr;
    assign w_active = (w_state != MEM_HALTED);

    mem_wait_ctrl #(.DMEM_TIMEOUT(DMEM_TIMEOUT)) u_wait_ctrl (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_en       (bus.EN),
        .i_memop    (w_memop),
        .i_halt     (r_entry.halt),
        .i_dhit     (bus.dhit),
        .o_state    (w_state),
        .o_advance  (w_advance),
        .o_complete (w_complete),
        .o_timeout  (w_timeout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_entry <= EXMEM_BUBBLE;
            r_dload <= '0;
        end else begin
            if (w_complete && r_entry.MemRd)
                r_dload <= bus.dmemload;
            if (w_advance)
                r_entry <= bus.flush ? EXMEM_BUBBLE : w_exe;
            else if (w_complete) begin
                // Drop the request bits so a completed access is not reissued.
                r_entry.MemRd <= 1'b0;
                r_entry.MemWr <= 1'b0;
            end
        end
    end

    assign bus.mem_alu_out   = r_entry.alu_out;
    assign bus.mem_rdat2     = r_entry.rdat2;
    assign bus.mem_pc_4      = r_entry.pc_4;
    assign bus.mem_br_target = r_entry.br_target;
    assign bus.mem_wsel      = r_entry.wsel;
    assign bus.mem_zero      = r_entry.zero;
    assign bus.mem_MemWr     = r_entry.MemWr;
    assign bus.mem_MemRd     = r_entry.MemRd;
    assign bus.mem_branch    = r_entry.branch;
    assign bus.mem_halt      = r_entry.halt;
    assign bus.mem_RegWr     = r_entry.RegWr;
    assign bus.mem_PCSrc     = r_entry.PCSrc;
    assign bus.mem_MemtoReg  = r_entry.MemtoReg;

    assign bus.dmemREN     = w_active && r_entry.MemRd;
    assign bus.dmemWEN     = w_active && r_entry.MemWr;
    assign bus.dmemaddr    = r_entry.alu_out;
    assign bus.dmemstore   = r_entry.rdat2;
    assign bus.mem_dload   = r_dload;
    assign bus.mem_stall   = w_active && w_memop && !bus.dhit;
    assign bus.mem_timeout = w_timeout;

endmodule

// File: tb/tb_execute_mem_reg.sv
// Scoreboard bench for execute_mem_reg: a behavioural model predicts each
// cycle's outputs, a monitor compares them against the DUT at the falling edge.
module tb_execute_mem_reg;
    localparam int TMO = 4;

    logic CLK = 1'b0;
    logic RST;
    execute_mem_reg_if bus();

    execute_mem_reg #(.DMEM_TIMEOUT(TMO)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] data;
        logic [14:0]  ctrl;
        logic [66:0]  req;
        logic [31:0]  dload;
        logic         tmo;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state: the latched entry plus access bookkeeping.
    logic [31:0] m_alu, m_rdat2, m_pc4, m_br, m_dload;
    logic [4:0]  m_wsel;
    logic        m_zero, m_wr, m_rd, m_branch, m_halt, m_regwr;
    logic [1:0]  m_pcsrc, m_mtr;
    logic        m_waiting, m_halted, m_timeout;
    int          m_wait_n;

    task automatic model_reset();
        {m_alu, m_rdat2, m_pc4, m_br, m_dload} = '0;
        {m_wsel, m_zero, m_wr, m_rd, m_branch, m_halt, m_regwr, m_pcsrc, m_mtr} = '0;
        m_waiting = 0; m_halted = 0; m_timeout = 0; m_wait_n = 0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        logic pend;
        e.data  = {m_alu, m_rdat2, m_pc4, m_br};
        e.ctrl  = {m_wsel, m_zero, m_wr, m_rd, m_branch, m_halt, m_regwr, m_pcsrc, m_mtr};
        e.req   = {!m_halted && m_rd, !m_halted && m_wr,
                   !m_halted && (m_rd || m_wr) && !bus.dhit, m_alu, m_rdat2};
        e.dload = m_dload;
        e.tmo   = m_timeout;
        q.push_back(e);

        pend = m_rd || m_wr;
        if (RST) model_reset();
        else if (!m_halted) begin
            if (pend && bus.dhit && m_rd) m_dload = bus.dmemload;
            if (m_waiting) begin
                if (m_wait_n < 255) m_wait_n++;
                if (m_wait_n == TMO) m_timeout = 1;
                if (bus.dhit) begin
                    m_rd = 0; m_wr = 0; m_waiting = 0; m_halted = m_halt;
                end
            end else if (pend && !bus.dhit) begin
                m_waiting = 1; m_wait_n = 0;
            end else if (m_halt) begin
                m_rd = 0; m_wr = 0; m_halted = 1;
            end else if (bus.EN) begin
                if (bus.flush) begin
                    {m_alu, m_rdat2, m_pc4, m_br} = '0;
                    {m_wsel, m_zero, m_wr, m_rd, m_branch, m_halt, m_regwr, m_pcsrc, m_mtr} = '0;
                end else begin
                    m_alu = bus.exe_alu_out; m_rdat2 = bus.exe_rdat2;
                    m_pc4 = bus.exe_pc_4;    m_br = bus.exe_br_target;
                    m_wsel = bus.exe_wsel;   m_zero = bus.exe_zero;
                    m_wr = bus.exe_MemWr;    m_rd = bus.exe_MemRd;
                    m_branch = bus.exe_branch; m_halt = bus.exe_halt;
                    m_regwr = bus.exe_RegWr; m_pcsrc = bus.exe_PCSrc;
                    m_mtr = bus.exe_MemtoReg;
                end
            end else begin
                m_rd = 0; m_wr = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic setin(input logic rst, input logic en, input logic fl, input logic dh,
                         input logic rd, input logic wr, input logic hlt, input logic rw,
                         input logic [31:0] alu, input logic [31:0] r2, input logic [31:0] ld);
        RST = rst; bus.EN = en; bus.flush = fl; bus.dhit = dh; bus.dmemload = ld;
        bus.exe_MemRd = rd; bus.exe_MemWr = wr; bus.exe_halt = hlt; bus.exe_RegWr = rw;
        bus.exe_alu_out = alu; bus.exe_rdat2 = r2;
        bus.exe_pc_4 = $urandom; bus.exe_br_target = $urandom;
        bus.exe_wsel = 5'($urandom); bus.exe_zero = 1'($urandom);
        bus.exe_branch = 1'($urandom); bus.exe_PCSrc = 2'($urandom);
        bus.exe_MemtoReg = 2'($urandom);
    endtask

    task automatic drive(input logic rst, input logic en, input logic fl, input logic dh,
                         input logic rd, input logic wr, input logic hlt, input logic rw,
                         input logic [31:0] alu, input logic [31:0] r2, input logic [31:0] ld);
        setin(rst, en, fl, dh, rd, wr, hlt, rw, alu, r2, ld);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pops one prediction per cycle and checks it mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("data", {bus.mem_alu_out, bus.mem_rdat2, bus.mem_pc_4, bus.mem_br_target}, e.data);
                chk("ctrl", 128'({bus.mem_wsel, bus.mem_zero, bus.mem_MemWr, bus.mem_MemRd,
                                  bus.mem_branch, bus.mem_halt, bus.mem_RegWr, bus.mem_PCSrc,
                                  bus.mem_MemtoReg}), 128'(e.ctrl));
                chk("memreq", 128'({bus.dmemREN, bus.dmemWEN, bus.mem_stall, bus.dmemaddr,
                                    bus.dmemstore}), 128'(e.req));
                chk("dload", 128'(bus.mem_dload), 128'(e.dload));
                chk("timeout", 128'(bus.mem_timeout), 128'(e.tmo));
            end
        end
    end

    initial begin
        setin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load with three miss cycles, then completion.
        drive(0, 1, 0, 0, 1, 0, 0, 1, 32'h100, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, $urandom, $urandom, 32'h0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        idle(2);

        // Store completing in its first cycle, entry advances.
        drive(0, 1, 0, 0, 0, 1, 0, 0, 32'h200, 32'h55, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 1, 32'h300, 32'h66, 0);
        idle(1);

        // Flush a register-writing store.
        drive(0, 1, 1, 0, 0, 1, 0, 1, 32'h400, 32'h77, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Watchdog: long miss then completion; flag stays set.
        drive(0, 1, 0, 0, 1, 0, 0, 0, 32'h500, 0, 0);
        for (int i = 0; i < 7; i++) drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h12345678);
        idle(2);

        // Reset mid-WAIT abandons the access.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0, 0, 32'h600, 0, 0);
        idle(2);
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'hCAFE);
        idle(3);

        // Halt: everything frozen until reset.
        drive(0, 1, 0, 0, 0, 0, 1, 1, 32'h700, 32'h88, 0);
        for (int i = 0; i < 6; i++)
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  0, 1, $urandom, $urandom, $urandom);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Halt together with a load: finish the access first.
        drive(0, 1, 0, 0, 1, 0, 1, 0, 32'h800, 0, 0);
        idle(2);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5);
        for (int i = 0; i < 3; i++)
            drive(0, 1, 0, 1, 1, 1, 0, 1, $urandom, $urandom, $urandom);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++)
            drive($urandom_range(99) < 3, $urandom_range(99) < 80, $urandom_range(99) < 10,
                  $urandom_range(99) < 40, $urandom_range(99) < 30, $urandom_range(99) < 25,
                  $urandom_range(99) < 3, 1'($urandom), $urandom, $urandom, $urandom);

        repeat (2) @(negedge CLK);
        chk("drain", 128'(q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
